mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side responder for the instruction-fetch and load/store request interfaces.
- Serialises 32-bit instruction fetches and 1/2/4-byte data loads and stores onto the single byte-wide RAM/IO port.
- Arbitrates between fetch and data requests and returns assembled little-endian results with single-cycle finished pulses.
- Sits between the fetch stage, the load/store unit and the top-level RAM/IO bus.

Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region (0x30000 and up).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes all state
- if_enable  in  1  fetch request, held until if_finished
- if_addr  in  32  fetch byte address
- jump_flush  in  1  abort any in-flight fetch
- if_finished  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched instruction, little-endian
- if_busy  out  1  controller serving a fetch
- mem_enable  in  1  data request, held until mem_finished
- mem_wr  in  1  1 = store, 0 = load
- mem_addr  in  32  data byte address
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
- mem_wdata  in  32  store data; low bytes used first
- mem_finished  out  1  one-cycle pulse
- mem_rdata  out  32  load data, zero-extended
- mem_busy  out  1  controller serving a data request
- io_buffer_full  in  1  IO output buffer full
- ram_din  in  8  read byte for the address driven in the previous cycle
- ram_dout  out  8  write byte
- ram_a  out  32  byte address
- ram_wr  out  1  write strobe

Behaviour:
- All outputs are registered.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Reset (rst = 0, asynchronous):
  - state goes to IDLE; byte counter and data registers clear.
  - every output goes to 0: finished pulses, busy flags, ram_a, ram_dout, ram_wr, if_inst, mem_rdata.
  - Reset mid-operation aborts with no finished pulse.
- rdy = 0: state, counters and data hold; ram_wr is forced to 0.
- IDLE:
  - mem_enable has priority over if_enable when both are high.
  - Accepting at edge E0 loads the base address and byte count N (fetch N = 4) and moves to IF_RD, MEM_RD or MEM_WR.
  - With nothing pending, ram_a = 0 and ram_wr = 0.
- IF_RD / MEM_RD:
  - ram_a = base+0 .. base+N-1 in cycles 1..N, with ram_wr = 0.
  - Byte k is captured from ram_din at the end of cycle k+2, into bits [8k+7:8k].
  - After the last capture the state moves to DONE: finished = 1 in cycle N+2, data valid that cycle.
- MEM_WR:
  - ram_a = base+k, ram_dout = mem_wdata[8k+7:8k], ram_wr = 1 in cycles 1..N.
  - After the last byte the state moves to DONE: mem_finished in cycle N+1.
- IO write stall: when addr[17:16] == IO_ADDR_HI and io_buffer_full = 1, the byte is not issued.
  - ram_wr = 0 and the counter holds until io_buffer_full = 0.
- DONE:
  - Lasts exactly one cycle; the matching finished pulse is high, then the state returns to IDLE.
  - Enables are ignored in DONE, so back-to-back fetches take N+3 cycles each.
- Busy flags:
  - if_busy = 1 in IF_RD.
  - mem_busy = 1 in MEM_RD and MEM_WR, including IO stall cycles.
- jump_flush:
  - In IF_RD: the fetch is aborted and the state returns to IDLE next cycle with no if_finished.
  - In IF_RD, a same-cycle if_enable is ignored.
  - In DONE the pulse is still emitted; the fetch stage discards it.
  - Ignored during MEM_RD and MEM_WR, so stores always complete.
- Addresses increment by 1 per byte with 32-bit wrap (0xFFFFFFFF → 0x00000000).
- mem_rdata holds its value until the next load completes; bytes beyond N are zero.
- if_inst holds until the next fetch completes.

Optional Feature:
- Macro: IO_WRITE_GAP_EN.
- Defined: after every IO-region write byte, the controller inserts two cycles with ram_wr = 0 before the next byte or before DONE. mem_busy stays 1 during the gap.
- Undefined: IO bytes issue back-to-back, limited only by io_buffer_full.

Test Plan:
- Fetch:
  - Stimulus: RAM[0x100..0x103] = 13,05,A0,00; if_enable with addr 0x100.
  - Response: ram_a = 0x100..0x103 in cycles 1–4; if_finished in cycle 6 only, with if_inst = 0x00A00513; if_busy in cycles 1–5.
- Arbitration:
  - Stimulus: mem_enable (load, len 01, addr 0x2000, RAM = 34,12) and if_enable high in the same IDLE cycle.
  - Response: mem_rdata = 0x00001234 first; the fetch starts after DONE.
- Store:
  - Stimulus: mem_wr, len 1x, addr 0x1FFFE, wdata 0xDEADBEEF.
  - Response: ram_wr = 1 with ram_a = 0x1FFFE..0x20001 and ram_dout = EF, BE, AD, DE; mem_finished in cycle 5.
- IO stall:
  - Stimulus: byte store to 0x30000 with io_buffer_full = 1 for 3 cycles.
  - Response: ram_wr stays 0 for 3 cycles, then one write of 0x41; mem_finished follows. With IO_WRITE_GAP_EN defined, 2 additional idle cycles precede DONE.
- Flush:
  - Stimulus: jump_flush in cycle 3 of a fetch.
  - Response: no if_finished; IDLE next cycle; a new fetch at 0x200 completes normally.
- Reset:
  - Stimulus: rst = 0 mid-load, asynchronous, between edges.
  - Response: all outputs go to 0 immediately; no finished pulse after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO responder for instruction fetches and 1/2/4-byte loads/stores.
// Optional feature macro IO_WRITE_GAP_EN: two idle cycles follow every IO-region write byte.
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    input  logic        jump_flush,
    output logic        if_finished,
    output logic [31:0] if_inst,
    output logic        if_busy,
    input  logic        mem_enable,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_finished,
    output logic [31:0] mem_rdata,
    output logic        mem_busy,
    input  logic        io_buffer_full,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned GW = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] buf_q, buf_d;

    logic          if_finished_d, mem_finished_d;
    logic          if_busy_d, mem_busy_d;
    logic [DW-1:0] if_inst_d, mem_rdata_d;
    logic [AW-1:0] ram_a_d;
    logic [BW-1:0] ram_dout_d;
    logic          ram_wr_d;

    logic [AW-1:0] wr_addr_c;
    logic [DW-1:0] wr_src_c;
    logic [BW-1:0] wr_byte_c;
    logic          wr_io_c, wr_stall_c, try_wr_c;
    logic [1:0]    rd_idx_c;

    function automatic logic [CW-1:0] len_bytes(input logic [1:0] len);
        return len[1] ? CW'(4) : (len[0] ? CW'(2) : CW'(1));
    endfunction

    // Next write byte: taken straight from the request when accepting in IDLE
    assign wr_addr_c  = ((state_q == IDLE) ? mem_addr : base_q) + AW'(cnt_q);
    assign wr_src_c   = (state_q == IDLE) ? mem_wdata : wdata_q;
    assign wr_byte_c  = BW'(wr_src_c >> {cnt_q[1:0], 3'b000});
    assign wr_io_c    = (wr_addr_c[17:16] == IO_ADDR_HI);
    assign wr_stall_c = wr_io_c && io_buffer_full;
    assign rd_idx_c   = 2'(cnt_q - CW'(2));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        n_d            = n_q;
        gap_d          = gap_q;
        base_d         = base_q;
        wdata_d        = wdata_q;
        buf_d          = buf_q;
        if_finished_d  = 1'b0;
        mem_finished_d = 1'b0;
        if_inst_d      = if_inst;
        mem_rdata_d    = mem_rdata;
        ram_a_d        = '0;
        ram_dout_d     = '0;
        ram_wr_d       = 1'b0;
        try_wr_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_enable) begin
                    base_d  = mem_addr;
                    n_d     = len_bytes(mem_len);
                    wdata_d = mem_wdata;
                    buf_d   = '0;
                    if (mem_wr) begin
                        state_d  = MEM_WR;
                        try_wr_c = 1'b1;
                    end else begin
                        state_d = MEM_RD;
                        ram_a_d = mem_addr;
                        cnt_d   = CW'(1);
                    end
                end else if (if_enable) begin
                    base_d  = if_addr;
                    n_d     = CW'(4);
                    buf_d   = '0;
                    state_d = IF_RD;
                    ram_a_d = if_addr;
                    cnt_d   = CW'(1);
                end
            end
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && jump_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // cnt_q is the current cycle number; RAM returns data two cycles after the address
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < n_q) begin
                        ram_a_d = base_q + AW'(cnt_q);
                    end
                    if (cnt_q >= CW'(2)) begin
                        buf_d[{rd_idx_c, 3'b000} +: BW] = ram_din;
                    end
                    if (cnt_q == n_q + CW'(1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        if (state_q == IF_RD) begin
                            if_finished_d = 1'b1;
                            if_inst_d     = buf_d;
                        end else begin
                            mem_finished_d = 1'b1;
                            mem_rdata_d    = buf_d;
                        end
                    end
                end
            end
            MEM_WR: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (cnt_q == n_q) begin
                    state_d        = DONE;
                    cnt_d          = '0;
                    mem_finished_d = 1'b1;
                end else begin
                    try_wr_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Issue one write byte unless the IO buffer is full; the counter only moves on issue
        if (try_wr_c && !wr_stall_c) begin
            ram_a_d    = wr_addr_c;
            ram_dout_d = wr_byte_c;
            ram_wr_d   = 1'b1;
            cnt_d      = cnt_q + CW'(1);
`ifdef IO_WRITE_GAP_EN
            if (wr_io_c) begin
                gap_d = GW'(2);
            end
`endif
        end

        if_busy_d  = (state_d == IF_RD);
        mem_busy_d = (state_d == MEM_RD) || (state_d == MEM_WR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            gap_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            if_finished  <= 1'b0;
            mem_finished <= 1'b0;
            if_busy      <= 1'b0;
            mem_busy     <= 1'b0;
            if_inst      <= '0;
            mem_rdata    <= '0;
            ram_a        <= '0;
            ram_dout     <= '0;
            ram_wr       <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            gap_q        <= gap_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            if_finished  <= if_finished_d;
            mem_finished <= mem_finished_d;
            if_busy      <= if_busy_d;
            mem_busy     <= mem_busy_d;
            if_inst      <= if_inst_d;
            mem_rdata    <= mem_rdata_d;
            ram_a        <= ram_a_d;
            ram_dout     <= ram_dout_d;
            ram_wr       <= ram_wr_d;
        end else begin
            ram_wr <= 1'b0;
        end
    end

endmodule
